// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-organised memory with no byte enables; sub-word stores are done as read-modify-write.
// Latency: load/SW done at T+2, SB/SH done at T+3, illegal or misaligned requests done at T+1.
// Backpressure: stall_o holds the pipeline from accept until DONE; no request is accepted in DONE.
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    input  logic                  is_store_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_we_o,
    output logic                  mem_re_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_DONE} state_t;

    typedef struct packed {
        logic                  is_store;
        logic [2:0]            funct3;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                state_q, state_d;
    req_t                  req_q, req_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] merge_q, merge_d;
    logic                  err_q, err_d;

    logic                  bad_req;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] merged;

    // Illegal encodings and misalignment are decided on the live request so errors never touch memory.
    always_comb begin
        bad_req = 1'b0;
        if (is_store_i) begin
            if (funct3_i[2] || funct3_i[1:0] == 2'b11) bad_req = 1'b1;
        end else begin
            if (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111) bad_req = 1'b1;
        end
        if (funct3_i[1:0] == 2'b01 && addr_i[0]) bad_req = 1'b1;
        if (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00) bad_req = 1'b1;
    end

    always_comb begin
        byte_sel = mem_rdata_i[{req_q.addr[1:0], 3'b000} +: 8];
        half_sel = mem_rdata_i[{req_q.addr[1], 4'b0000} +: 16];
        case (req_q.funct3)
            3'b000:  load_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_ext = mem_rdata_i;
        endcase

        merged = mem_rdata_i;
        if (req_q.funct3[1:0] == 2'b00)
            merged[{req_q.addr[1:0], 3'b000} +: 8] = req_q.wdata[7:0];
        else
            merged[{req_q.addr[1], 4'b0000} +: 16] = req_q.wdata[15:0];
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    req_d   = '{is_store: is_store_i, funct3: funct3_i, addr: addr_i, wdata: wdata_i};
                    rdata_d = '0;
                    err_d   = bad_req;
                    merge_d = wdata_i;
                    if (bad_req)                   state_d = S_DONE;
                    else if (!is_store_i)          state_d = S_LOAD;
                    else if (funct3_i[1:0] == 2'b10) state_d = S_WRITE;
                    else                           state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                rdata_d = load_ext;
                state_d = S_DONE;
            end
            S_RMW_RD: begin
                merge_d = merged;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            merge_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
            err_q   <= err_d;
        end
    end

    assign stall_o     = (state_q == S_IDLE && req_valid_i) || state_q == S_LOAD
                         || state_q == S_RMW_RD || state_q == S_WRITE;
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = {req_q.addr[DATA_WIDTH-1:2], 2'b00};
    assign mem_wdata_o = merge_q;
    assign mem_we_o    = (state_q == S_WRITE);
    assign mem_re_o    = (state_q == S_LOAD) || (state_q == S_RMW_RD);

endmodule
